// File: rtl/clk_en_synth_pkg.sv
// clk_en_synth_pkg: shared types and helpers for the clock-enable synthesizer.
// Revision: 1.0
`default_nettype none

package clk_en_synth_pkg;

  typedef enum logic {
    MODE_FRAC = 1'b0,
    MODE_INT  = 1'b1
  } mode_t;

  // Storage widths of the config record; the block supports up to 16 channels and 64-bit rates.
  localparam int CH_MAX_W  = 4;
  localparam int INC_MAX_W = 64;

  function automatic int CH_W(input int num_ch);
    return ($clog2(num_ch) < 1) ? 1 : $clog2(num_ch);
  endfunction

  typedef struct packed {
    logic [CH_MAX_W-1:0]  ch;
    mode_t                mode;
    logic [INC_MAX_W-1:0] inc;
  } cfg_t;

endpackage

`default_nettype wire

// File: rtl/clk_en_synth_if.sv
// clk_en_synth_if: configuration valid/ready handshake bundle.
// Revision: 1.0
`default_nettype none

interface clk_en_synth_if #(
  parameter int NUM_CH = 4,
  parameter int ACC_W  = 32
) ();
  import clk_en_synth_pkg::*;

  localparam int CW = CH_W(NUM_CH);

  logic            cfg_valid;
  logic            cfg_ready;
  logic [CW-1:0]   cfg_ch;
  mode_t           cfg_mode;
  logic [ACC_W-1:0] cfg_inc;

  modport master (
    output cfg_valid,
    output cfg_ch,
    output cfg_mode,
    output cfg_inc,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_ch,
    input  cfg_mode,
    input  cfg_inc,
    output cfg_ready
  );

endinterface

`default_nettype wire

// File: rtl/clk_en_synth_ch.sv
// clk_en_ch: one enable channel (integer divider or fractional NCO) with settle/lock tracking.
// Revision: 1.0
`default_nettype none

module clk_en_ch
  import clk_en_synth_pkg::*;
#(
  parameter int               ACC_W     = 32,
  parameter int               SETTLE_CE = 16,
  parameter logic [ACC_W-1:0] DEF_INC   = '0,
  parameter mode_t            DEF_MODE  = MODE_FRAC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             apply,
  input  mode_t            pend_mode,
  input  logic [ACC_W-1:0] pend_inc,
  output logic             ready_to_apply,
  output logic             ce,
  output logic             locked
);

  localparam int               SET_W      = $clog2(SETTLE_CE + 1);
  localparam logic [SET_W-1:0] SETTLE_MAX = SET_W'(SETTLE_CE);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] inc;
  mode_t            mode;
  logic [SET_W-1:0] settle;
  logic [ACC_W:0]   sum;
  logic             enabled;
  logic             fire;

  always_comb begin
    enabled = (inc != '0);
    sum     = {1'b0, acc} + {1'b0, inc};
    fire    = 1'b0;
    if (enabled) begin
      if (mode == MODE_INT) fire = (acc == inc - ACC_W'(1));
      else                  fire = sum[ACC_W];
    end
  end

  // A running channel only switches rate on the cycle its next pulse is registered.
  assign ready_to_apply = !enabled || fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      inc    <= DEF_INC;
      mode   <= DEF_MODE;
      settle <= '0;
      locked <= 1'b0;
      ce     <= 1'b0;
    end else begin
      ce <= fire;
      if (apply) begin
        acc    <= '0;
        inc    <= pend_inc;
        mode   <= pend_mode;
        settle <= '0;
        locked <= 1'b0;
      end else begin
        if (enabled) begin
          if (mode == MODE_INT) acc <= fire ? '0 : acc + ACC_W'(1);
          else                  acc <= sum[ACC_W-1:0];
        end
        if (fire && settle != SETTLE_MAX) settle <= settle + SET_W'(1);
        locked <= enabled && (settle == SETTLE_MAX);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/clk_en_synth.sv
// clk_en_synth: multi-channel runtime-reconfigurable clock-enable synthesizer.
// Revision: 1.0
`default_nettype none

module clk_en_synth
  import clk_en_synth_pkg::*;
#(
  parameter int               NUM_CH    = 4,
  parameter int               ACC_W     = 32,
  parameter int               SETTLE_CE = 16,
  parameter logic [ACC_W-1:0] DEF_INC   = '0,
  parameter int               DEF_MODE  = 0
) (
  input  logic              refclk,
  input  logic              rst_n,
  clk_en_synth_if.slave     cfg,
  output logic [NUM_CH-1:0] ce,
  output logic [NUM_CH-1:0] locked,
  output logic              all_locked
);

  localparam mode_t RST_MODE = (DEF_MODE != 0) ? MODE_INT : MODE_FRAC;

  cfg_t              pend;
  logic              pend_valid;
  logic              ready_q;
  logic              pend_bad;
  logic              pend_done;
  logic [NUM_CH-1:0] ch_ready;
  logic [NUM_CH-1:0] ch_apply;
  logic              unused_pend_inc;

  // Upper rate bits beyond ACC_W are always zero-filled.
  assign unused_pend_inc = ^pend.inc;

  assign pend_bad      = (32'(pend.ch) >= 32'(NUM_CH));
  assign pend_done     = (|ch_apply) || (pend_valid && pend_bad);
  assign cfg.cfg_ready = ready_q;

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign ch_apply[i] = pend_valid && (pend.ch == CH_MAX_W'(i)) && ch_ready[i];

      clk_en_ch #(
        .ACC_W     (ACC_W),
        .SETTLE_CE (SETTLE_CE),
        .DEF_INC   (DEF_INC),
        .DEF_MODE  (RST_MODE)
      ) u_ch (
        .clk            (refclk),
        .rst_n          (rst_n),
        .apply          (ch_apply[i]),
        .pend_mode      (pend.mode),
        .pend_inc       (pend.inc[ACC_W-1:0]),
        .ready_to_apply (ch_ready[i]),
        .ce             (ce[i]),
        .locked         (locked[i])
      );
    end
  endgenerate

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid <= 1'b0;
      pend       <= '0;
      ready_q    <= 1'b1;
      all_locked <= 1'b0;
    end else begin
      all_locked <= &locked;
      if (cfg.cfg_valid && ready_q) begin
        pend_valid <= 1'b1;
        pend.ch    <= CH_MAX_W'(cfg.cfg_ch);
        pend.mode  <= cfg.cfg_mode;
        pend.inc   <= INC_MAX_W'(cfg.cfg_inc);
        ready_q    <= 1'b0;
      end else if (pend_done) begin
        pend_valid <= 1'b0;
        ready_q    <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire
